// File: rtl/edge_pulse_gen.sv
// Multi-channel edge detector. Each channel synchronizes an asynchronous level input,
// debounces it, and emits a retriggerable pulse on the selected edges of the
// debounced level.
module edge_pulse_gen #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned PULSE_LEN     = 1,
  parameter bit          RESET_LEVEL   = 1'b0
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [CHANNELS-1:0] i_In,
  input  logic [1:0]          i_Mode,
  output logic [CHANNELS-1:0] o_Out,
  output logic [CHANNELS-1:0] o_Level
);

  // The debounce counter only ever needs to reach STABLE_CYCLES-1; the pulse counter
  // must hold PULSE_LEN itself.
  localparam int unsigned CntW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned PulseW = $clog2(PULSE_LEN + 1);

  localparam logic [CntW-1:0]   CntMax    = CntW'(STABLE_CYCLES - 1);
  localparam logic [PulseW-1:0] PulseLoad = PulseW'(PULSE_LEN);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_s;

  logic [CntW-1:0]     deb_cnt_q   [CHANNELS];
  logic [CntW-1:0]     deb_cnt_d   [CHANNELS];
  logic [PulseW-1:0]   pulse_cnt_q [CHANNELS];
  logic [PulseW-1:0]   pulse_cnt_d [CHANNELS];

  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] event_ok;

  // Synchronizer chain; the reset value matches the debounced level so that reset
  // release by itself never looks like an input change.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {CHANNELS{RESET_LEVEL}};
      end
    end else begin
      sync_q[0] <= i_In;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Debounce, edge qualification and pulse counting per channel.
  always_comb begin
    level_d     = level_q;
    deb_cnt_d   = deb_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    event_ok    = '0;
    out_d       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sync_s[c] == level_q[c]) begin
        deb_cnt_d[c] = '0;
      end else if (deb_cnt_q[c] == CntMax) begin
        level_d[c]   = sync_s[c];
        deb_cnt_d[c] = '0;
        // Rising events need mode bit 0, falling events need mode bit 1.
        event_ok[c]  = sync_s[c] ? i_Mode[0] : i_Mode[1];
      end else begin
        deb_cnt_d[c] = deb_cnt_q[c] + CntW'(1);
      end

      // A qualified event reloads even mid-pulse, so back-to-back events never gap.
      if (event_ok[c]) begin
        pulse_cnt_d[c] = PulseLoad;
      end else if (pulse_cnt_q[c] != '0) begin
        pulse_cnt_d[c] = pulse_cnt_q[c] - PulseW'(1);
      end
      out_d[c] = (pulse_cnt_d[c] != '0);
    end
  end

  // Debounced level, counters and registered pulse output.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      level_q <= {CHANNELS{RESET_LEVEL}};
      out_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        deb_cnt_q[c]   <= '0;
        pulse_cnt_q[c] <= '0;
      end
    end else begin
      level_q     <= level_d;
      out_q       <= out_d;
      deb_cnt_q   <= deb_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign o_Out   = out_q;
  assign o_Level = level_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Bench for edge_pulse_gen: two instances (slow debounce / short pulse, and
// no debounce / long pulse) checked against a timestamp-based reference model.
module tb_edge_pulse_gen;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int KA   = 4;
  localparam int PA   = 3;
  localparam int KB   = 1;
  localparam int PB   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] in_v;
  logic [1:0]    mode;
  logic [CH-1:0] out_a, lvl_a, out_b, lvl_b;

  int errors = 0;
  int checks = 0;

  // Model state: input delay line, debounced level, length of the current run of
  // samples disagreeing with the level, and cycles elapsed since the last
  // qualified event (saturating at the pulse length).
  logic [CH-1:0] m_pipe [2][SYNC];
  logic [CH-1:0] m_level [2];
  int            m_run [2][CH];
  int            m_age [2][CH];

  edge_pulse_gen #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(KA), .PULSE_LEN(PA), .RESET_LEVEL(1'b0)
  ) u_dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_In(in_v), .i_Mode(mode), .o_Out(out_a), .o_Level(lvl_a)
  );

  edge_pulse_gen #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(KB), .PULSE_LEN(PB), .RESET_LEVEL(1'b0)
  ) u_dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_In(in_v), .i_Mode(mode), .o_Out(out_b), .o_Level(lvl_b)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input int d, input int k, input int p);
    logic [CH-1:0] s;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) m_pipe[d][i] = '0;
      m_level[d] = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[d][c] = 0;
        m_age[d][c] = p;
      end
    end else begin
      s = m_pipe[d][SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_pipe[d][i] = m_pipe[d][i-1];
      m_pipe[d][0] = in_v;
      for (int c = 0; c < CH; c++) begin
        if (m_age[d][c] < p) m_age[d][c]++;
        if (s[c] !== m_level[d][c]) begin
          m_run[d][c]++;
          if (m_run[d][c] == k) begin
            m_run[d][c]      = 0;
            m_level[d][c]    = s[c];
            if ((s[c] && mode[0]) || (!s[c] && mode[1])) m_age[d][c] = 0;
          end
        end else begin
          m_run[d][c] = 0;
        end
      end
    end
  endtask

  function automatic logic [CH-1:0] m_out(input int d, input int p);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = (m_age[d][c] < p);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(0, KA, PA);
    model_edge(1, KB, PB);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    in_v = '0;
    mode = 2'b00;
    tick();
    tick();
    checks++;
    if (out_a !== 4'b0000 || lvl_a !== 4'b0000) begin
      errors++;
      $display("FAIL reset_a: out=%b lvl=%b want 0000/0000", out_a, lvl_a);
    end
    checks++;
    if (out_b !== 4'b0000 || lvl_b !== 4'b0000) begin
      errors++;
      $display("FAIL reset_b: out=%b lvl=%b want 0000/0000", out_b, lvl_b);
    end
    rst = 1'b0;
    settle(3);
  endtask

  task automatic test_rise();
    logic [CH-1:0] exp_out, exp_lvl;
    mode = 2'b01;
    in_v = 4'b0001;
    for (int e = 0; e <= 8; e++) begin
      tick();
      exp_lvl = (e >= 5) ? 4'b0001 : 4'b0000;
      exp_out = (e >= 5 && e <= 7) ? 4'b0001 : 4'b0000;
      checks++;
      if (out_a !== exp_out || lvl_a !== exp_lvl) begin
        errors++;
        $display("FAIL rise_e%0d: out=%b lvl=%b want %b/%b", e, out_a, lvl_a, exp_out, exp_lvl);
      end
    end
    in_v = '0;
    settle(10);
  endtask

  task automatic test_falling();
    int rise_hi, fall_hi;
    rise_hi = 0;
    fall_hi = 0;
    mode = 2'b10;
    in_v = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_a[1]) rise_hi++;
    end
    in_v = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_a[1]) fall_hi++;
      checks++;
      if (out_a !== m_out(0, PA) || lvl_a !== m_level[0]) begin
        errors++;
        $display("FAIL falling_model: out=%b lvl=%b want %b/%b", out_a, lvl_a, m_out(0, PA),
                 m_level[0]);
      end
    end
    checks++;
    if (rise_hi != 0 || fall_hi != PA) begin
      errors++;
      $display("FAIL falling_pulse: rise_hi=%0d fall_hi=%0d want 0/%0d", rise_hi, fall_hi, PA);
    end
  endtask

  task automatic test_glitch();
    int lvl_hi, out_hi;
    mode   = 2'b11;
    lvl_hi = 0;
    out_hi = 0;
    in_v   = 4'b0100;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) in_v = '0;
      tick();
      if (lvl_a[2]) lvl_hi++;
      if (out_a[2]) out_hi++;
    end
    checks++;
    if (lvl_hi != 0 || out_hi != 0) begin
      errors++;
      $display("FAIL glitch_short: lvl_hi=%0d out_hi=%0d want 0/0", lvl_hi, out_hi);
    end
    lvl_hi = 0;
    in_v   = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) in_v = '0;
      tick();
      if (lvl_a[2]) lvl_hi++;
      checks++;
      if (out_a !== m_out(0, PA) || lvl_a !== m_level[0]) begin
        errors++;
        $display("FAIL glitch_model: out=%b lvl=%b want %b/%b", out_a, lvl_a, m_out(0, PA),
                 m_level[0]);
      end
    end
    checks++;
    if (lvl_hi != KA) begin
      errors++;
      $display("FAIL glitch_long: lvl_hi=%0d want %0d", lvl_hi, KA);
    end
    settle(6);
  endtask

  task automatic test_back_to_back();
    int hi, first, last;
    mode  = 2'b11;
    hi    = 0;
    first = -1;
    last  = -1;
    for (int t = 0; t < 30; t++) begin
      if (t % 4 == 0 && t <= 16) in_v[3] = ~in_v[3];
      tick();
      if (out_b[3]) begin
        hi++;
        if (first < 0) first = t;
        last = t;
      end
      checks++;
      if (out_b !== m_out(1, PB) || lvl_b !== m_level[1]) begin
        errors++;
        $display("FAIL b2b_model: out=%b lvl=%b want %b/%b", out_b, lvl_b, m_out(1, PB),
                 m_level[1]);
      end
    end
    checks++;
    if (hi != 24 || last - first + 1 != 24) begin
      errors++;
      $display("FAIL b2b_span: high=%0d span=%0d want 24/24", hi, last - first + 1);
    end
    in_v = '0;
    settle(12);
  endtask

  task automatic test_reset_mid_pulse();
    int waited;
    mode   = 2'b01;
    in_v   = 4'b0001;
    waited = 0;
    while (!out_a[0] && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (!out_a[0]) begin
      errors++;
      $display("FAIL midrst_wait: out=%b want bit0 set within 20 clocks", out_a);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (out_a !== 4'b0000 || lvl_a !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_drop: out=%b lvl=%b want 0000/0000", out_a, lvl_a);
    end
    rst = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e == 4 || e == 5) begin
        checks++;
        if (lvl_a[0] !== (e == 5) || out_a[0] !== (e == 5)) begin
          errors++;
          $display("FAIL midrst_e%0d: lvl0=%b out0=%b want %b", e, lvl_a[0], out_a[0], e == 5);
        end
      end
      checks++;
      if (out_a !== m_out(0, PA) || lvl_a !== m_level[0]) begin
        errors++;
        $display("FAIL midrst_model: out=%b lvl=%b want %b/%b", out_a, lvl_a, m_out(0, PA),
                 m_level[0]);
      end
    end
    in_v = '0;
    settle(12);
  endtask

  task automatic test_mode_none();
    mode = 2'b00;
    for (int t = 0; t < 48; t++) begin
      if (t % 12 == 0) in_v = ~in_v;
      tick();
      checks++;
      if (out_a !== 4'b0000 || out_b !== 4'b0000 || lvl_a !== m_level[0]
          || lvl_b !== m_level[1]) begin
        errors++;
        $display("FAIL mode_none: out_a=%b out_b=%b lvl_a=%b lvl_b=%b want 0000/0000/%b/%b",
                 out_a, out_b, lvl_a, lvl_b, m_level[0], m_level[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(5) == 0) in_v[c] = ~in_v[c];
      end
      if (t % 16 == 0) mode = 2'($urandom_range(3));
      rst = ($urandom_range(99) == 0);
      tick();
      checks++;
      if (out_a !== m_out(0, PA) || lvl_a !== m_level[0]) begin
        errors++;
        $display("FAIL random_a t=%0d: out=%b lvl=%b want %b/%b", t, out_a, lvl_a,
                 m_out(0, PA), m_level[0]);
      end
      checks++;
      if (out_b !== m_out(1, PB) || lvl_b !== m_level[1]) begin
        errors++;
        $display("FAIL random_b t=%0d: out=%b lvl=%b want %b/%b", t, out_b, lvl_b,
                 m_out(1, PB), m_level[1]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_falling();
    test_glitch();
    test_back_to_back();
    test_reset_mid_pulse();
    test_mode_none();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
